// File: rtl/header_lsu_if.sv
// Request, response and memory-side signals of the header load/store unit.
// The master modport is the environment (core plus memory); the slave modport is the LSU.
interface header_lsu_if #(
  parameter int DATA_W = 64
);
  logic              req_val_i;
  logic [1:0]        req_op_i;
  logic [DATA_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_size_i;
  logic [DATA_W-1:0] req_next_addr_i;
  logic              lsu_ready_o;
  logic              rsp_val_o;
  logic              rsp_err_o;
  logic [DATA_W-1:0] rsp_size_o;
  logic [DATA_W-1:0] rsp_addr_o;
  logic [DATA_W-1:0] rsp_next_addr_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  lsu_ready_o, rsp_val_o, rsp_err_o, rsp_size_o, rsp_addr_o, rsp_next_addr_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output lsu_ready_o, rsp_val_o, rsp_err_o, rsp_size_o, rsp_addr_o, rsp_next_addr_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/header_lsu.sv
// Free-list header load/store unit: one two-word header request at a time,
// sequenced onto a single-port memory with grant/rvalid handshakes.
//
// state      | meaning
// S_IDLE     | ready for a request
// S_W0_REQ   | size word access requested, waiting for grant
// S_W0_WAIT  | size word read granted, waiting for rvalid (LOAD only)
// S_W1_REQ   | next_addr word access requested, waiting for grant
// S_W1_WAIT  | next_addr word read granted, waiting for rvalid (LOAD only)
// S_RSP      | one-cycle response
module header_lsu #(
  parameter int DATA_W = 64,
  parameter int WORD_B = DATA_W / 8
) (
  input logic         clk_i,
  input logic         rst_ni,
  header_lsu_if.slave bus
);

  localparam int                OFF_W    = $clog2(WORD_B);
  localparam logic [DATA_W-1:0] C_WORD_B = DATA_W'(WORD_B);
  localparam logic [1:0]        OP_LOAD       = 2'd0;
  localparam logic [1:0]        OP_STORE_NEXT = 2'd2;
  localparam logic [1:0]        OP_RSVD       = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W0_REQ  = 3'd1,
    S_W0_WAIT = 3'd2,
    S_W1_REQ  = 3'd3,
    S_W1_WAIT = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_load;
  logic              r_err;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_size;
  logic [DATA_W-1:0] r_next;

  logic              w_accept;
  logic              w_req_err;
  logic [DATA_W-1:0] w_addr_w1;

  assign w_accept  = bus.req_val_i && (r_state == S_IDLE);
  assign w_req_err = (bus.req_op_i == OP_RSVD) || (bus.req_addr_i[OFF_W-1:0] != '0);
  assign w_addr_w1 = r_addr + C_WORD_B;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response fields double as the write-data holding registers; LOAD overwrites them with read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      r_addr <= '0;
      r_size <= '0;
      r_next <= '0;
    end else begin
      if (w_accept) begin
        r_load <= (bus.req_op_i == OP_LOAD);
        r_err  <= w_req_err;
        r_addr <= bus.req_addr_i;
        r_size <= bus.req_size_i;
        r_next <= bus.req_next_addr_i;
      end
      if ((r_state == S_W0_WAIT) && bus.mem_rvalid_i) begin
        r_size <= bus.mem_rdata_i;
      end
      if ((r_state == S_W1_WAIT) && bus.mem_rvalid_i) begin
        r_next <= bus.mem_rdata_i;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.lsu_ready_o  = 1'b0;
    bus.rsp_val_o    = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    case (r_state)
      S_IDLE: begin
        bus.lsu_ready_o = 1'b1;
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RSP;
          end else if (bus.req_op_i == OP_STORE_NEXT) begin
            w_state_nxt = S_W1_REQ;
          end else begin
            w_state_nxt = S_W0_REQ;
          end
        end
      end
      S_W0_REQ: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = !r_load;
        bus.mem_addr_o  = r_addr;
        bus.mem_wdata_o = r_load ? '0 : r_size;
        if (bus.mem_gnt_i) begin
          w_state_nxt = r_load ? S_W0_WAIT : S_W1_REQ;
        end
      end
      S_W0_WAIT: begin
        if (bus.mem_rvalid_i) begin
          w_state_nxt = S_W1_REQ;
        end
      end
      S_W1_REQ: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = !r_load;
        bus.mem_addr_o  = w_addr_w1;
        bus.mem_wdata_o = r_load ? '0 : r_next;
        if (bus.mem_gnt_i) begin
          w_state_nxt = r_load ? S_W1_WAIT : S_RSP;
        end
      end
      S_W1_WAIT: begin
        if (bus.mem_rvalid_i) begin
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        bus.rsp_val_o = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rsp_err_o       = r_err;
  assign bus.rsp_size_o      = r_size;
  assign bus.rsp_addr_o      = r_addr;
  assign bus.rsp_next_addr_o = r_next;

endmodule

// File: tb/tb_header_lsu.sv
// Randomized bench for header_lsu: a memory agent with configurable grant/rvalid delays,
// and a reference model that predicts responses, memory accesses and latency.
module tb_header_lsu;

  localparam int DATA_W = 64;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } acc_t;

  logic clk_i = 1'b0;
  logic rst_ni;

  header_lsu_if #(.DATA_W(DATA_W)) bus ();

  header_lsu #(.DATA_W(DATA_W)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          agent_en = 1'b1;
  int          cfg_gw [2];
  int          cfg_rd [2];
  int          acc_idx;
  bit          stab_ok;
  acc_t        acc_q [$];
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  function automatic logic [63:0] env_rd(input logic [63:0] a);
    return env_mem.exists(a) ? env_mem[a] : 64'd0;
  endfunction

  task automatic set_cfg(input int gw0, input int rd0, input int gw1, input int rd1);
    cfg_gw[0] = gw0; cfg_rd[0] = rd0;
    cfg_gw[1] = gw1; cfg_rd[1] = rd1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, bus.lsu_ready_o, 1);
    chk({tag, "_rsp_val"}, bus.rsp_val_o, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err_o, 0);
    chk({tag, "_rsp_size"}, bus.rsp_size_o, 0);
    chk({tag, "_rsp_addr"}, bus.rsp_addr_o, 0);
    chk({tag, "_rsp_next"}, bus.rsp_next_addr_o, 0);
    chk({tag, "_mem_req"}, bus.mem_req_o, 0);
    chk({tag, "_mem_we"}, bus.mem_we_o, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
  endtask

  // Memory agent: grant after cfg_gw idle request cycles, read data cfg_rd cycles after grant.
  initial begin : mem_agent
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] rd_val;
    logic        we;
    int          gw;
    int          rd;
    bit          stable;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (agent_en && bus.mem_req_o) begin
        a  = bus.mem_addr_o;
        we = bus.mem_we_o;
        wd = bus.mem_wdata_o;
        gw = (acc_idx < 2) ? cfg_gw[acc_idx] : 0;
        rd = (acc_idx < 2) ? cfg_rd[acc_idx] : 1;
        stable = 1'b1;
        for (int i = 0; i < gw; i++) begin
          @(negedge clk_i);
          if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== a ||
              bus.mem_we_o !== we || bus.mem_wdata_o !== wd) stable = 1'b0;
        end
        bus.mem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.mem_gnt_i = 1'b0;
        if (!stable) stab_ok = 1'b0;
        if (we) begin
          env_mem[a] = wd;
          acc_q.push_back('{we: 1'b1, addr: a, data: wd});
        end else begin
          rd_val = env_rd(a);
          acc_q.push_back('{we: 1'b0, addr: a, data: rd_val});
          repeat (rd - 1) begin
            @(posedge clk_i);
            #1;
          end
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rd_val;
          @(posedge clk_i);
          #1;
          bus.mem_rvalid_i = 1'b0;
          bus.mem_rdata_i  = '0;
        end
        acc_idx++;
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] sz,
                        input logic [63:0] nx, input bit hold_busy,
                        output logic [63:0] o_size, output logic [63:0] o_next, output int o_lat);
    acc_t        exp_q [$];
    logic [63:0] a1;
    logic [63:0] e_size;
    logic [63:0] e_next;
    logic        err;
    int          lat;
    int          k;
    bit          got;
    int          n;
    a1     = addr + 64'd8;
    err    = (op == 2'd3) || (addr[2:0] != 3'd0);
    e_size = sz;
    e_next = nx;
    lat    = 1;
    if (!err) begin
      case (op)
        2'd0: begin
          e_size = ref_rd(addr);
          e_next = ref_rd(a1);
          exp_q.push_back('{we: 1'b0, addr: addr, data: e_size});
          exp_q.push_back('{we: 1'b0, addr: a1, data: e_next});
          lat = 5 + cfg_gw[0] + cfg_gw[1] + (cfg_rd[0] - 1) + (cfg_rd[1] - 1);
        end
        2'd1: begin
          exp_q.push_back('{we: 1'b1, addr: addr, data: sz});
          exp_q.push_back('{we: 1'b1, addr: a1, data: nx});
          ref_mem[addr] = sz;
          ref_mem[a1]   = nx;
          lat = 3 + cfg_gw[0] + cfg_gw[1];
        end
        default: begin
          exp_q.push_back('{we: 1'b1, addr: a1, data: nx});
          ref_mem[a1] = nx;
          lat = 2 + cfg_gw[0];
        end
      endcase
    end
    acc_q.delete();
    acc_idx = 0;
    stab_ok = 1'b1;

    @(negedge clk_i);
    chk("ready_idle", bus.lsu_ready_o, 1);
    bus.req_val_i       = 1'b1;
    bus.req_op_i        = op;
    bus.req_addr_i      = addr;
    bus.req_size_i      = sz;
    bus.req_next_addr_i = nx;
    @(posedge clk_i);
    #1;
    bus.req_val_i       = hold_busy;
    bus.req_op_i        = 2'($urandom_range(0, 3));
    bus.req_addr_i      = {$urandom, $urandom};
    bus.req_size_i      = {$urandom, $urandom};
    bus.req_next_addr_i = {$urandom, $urandom};

    k   = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk_i);
      k++;
      if (k == 1) chk("ready_busy", bus.lsu_ready_o, 0);
      if (bus.rsp_val_o) got = 1'b1;
    end
    bus.req_val_i = 1'b0;
    chk("rsp_seen", got, 1);
    chk("latency", k, lat);
    chk("rsp_err", bus.rsp_err_o, err);
    chk("rsp_addr", bus.rsp_addr_o, addr);
    if (!err) begin
      chk("rsp_size", bus.rsp_size_o, e_size);
      chk("rsp_next", bus.rsp_next_addr_o, e_next);
    end
    o_size = bus.rsp_size_o;
    o_next = bus.rsp_next_addr_o;
    o_lat  = k;
    @(negedge clk_i);
    chk("rsp_pulse", bus.rsp_val_o, 0);
    chk("acc_cnt", acc_q.size(), exp_q.size());
    n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("acc_we", acc_q[i].we, exp_q[i].we);
      chk("acc_addr", acc_q[i].addr, exp_q[i].addr);
      chk("acc_data", acc_q[i].data, exp_q[i].data);
    end
    chk("req_stable", stab_ok, 1);
  endtask

  initial begin : main
    logic [63:0] s;
    logic [63:0] nx;
    logic [63:0] addr;
    logic [1:0]  op;
    int          lat;
    int          sel;
    bit          quiet;

    rst_ni              = 1'b0;
    bus.req_val_i       = 1'b0;
    bus.req_op_i        = '0;
    bus.req_addr_i      = '0;
    bus.req_size_i      = '0;
    bus.req_next_addr_i = '0;
    set_cfg(0, 1, 0, 1);
    repeat (2) @(negedge clk_i);
    check_reset("rst");
    rst_ni = 1'b1;

    env_mem[64'h100] = 64'h40;
    env_mem[64'h108] = 64'h200;
    ref_mem[64'h100] = 64'h40;
    ref_mem[64'h108] = 64'h200;

    // Directed: load, store, store_next, errors, stalled load
    do_req(2'd0, 64'h100, 64'h0, 64'h0, 1'b0, s, nx, lat);
    chk("t1_size", s, 64'h40);
    chk("t1_next", nx, 64'h200);
    chk("t1_lat", lat, 5);

    do_req(2'd1, 64'h200, 64'h30, 64'h0, 1'b0, s, nx, lat);
    chk("t2_mem_lo", env_rd(64'h200), 64'h30);
    chk("t2_lat", lat, 3);

    do_req(2'd2, 64'h100, 64'h0, 64'h300, 1'b0, s, nx, lat);
    chk("t3_size_kept", env_rd(64'h100), 64'h40);
    chk("t3_next_mem", env_rd(64'h108), 64'h300);
    chk("t3_lat", lat, 2);

    do_req(2'd0, 64'h104, 64'h0, 64'h0, 1'b0, s, nx, lat);
    do_req(2'd3, 64'h100, 64'h0, 64'h0, 1'b0, s, nx, lat);

    set_cfg(3, 3, 0, 1);
    do_req(2'd0, 64'h100, 64'h0, 64'h0, 1'b1, s, nx, lat);
    chk("t5_lat", lat, 10);
    set_cfg(0, 1, 0, 1);

    // Reset while the size-word read is outstanding, then a stray rvalid
    agent_en = 1'b0;
    @(negedge clk_i);
    bus.req_val_i  = 1'b1;
    bus.req_op_i   = 2'd0;
    bus.req_addr_i = 64'h100;
    @(posedge clk_i);
    #1;
    bus.req_val_i = 1'b0;
    @(negedge clk_i);
    chk("t6_req", bus.mem_req_o, 1);
    bus.mem_gnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.mem_gnt_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("t6");
    @(negedge clk_i);
    rst_ni           = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEAD_BEEF;
    @(posedge clk_i);
    #1;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (bus.rsp_val_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.lsu_ready_o !== 1'b1) quiet = 1'b0;
    end
    chk("t6_quiet", quiet, 1);
    agent_en = 1'b1;
    do_req(2'd0, 64'h100, 64'h0, 64'h0, 1'b0, s, nx, lat);

    // Randomized traffic over a small window, plus the wrapping top slot
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      addr = 64'h1000 + 64'($urandom_range(0, 15)) * 64'd8;
      if ($urandom_range(0, 9) == 0) addr = addr | 64'($urandom_range(1, 7));
      if ($urandom_range(0, 11) == 0) addr = 64'hFFFF_FFFF_FFFF_FFF8;
      set_cfg($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(1, 3));
      do_req(op, addr, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), s, nx, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
